// File: rtl/button_parser_pkg.sv
// Shared constants for the button conditioning chain: board defaults
// and reduced values that keep simulation short.
package button_parser_pkg;

  localparam int DEF_WIDTH          = 4;
  localparam int DEF_SAMPLE_CNT_MAX = 62500;  // 500 us at 125 MHz
  localparam int DEF_PULSE_CNT_MAX  = 200;
  localparam int SIM_SAMPLE_CNT_MAX = 4;
  localparam int SIM_PULSE_CNT_MAX  = 3;

endpackage

// File: rtl/button_parser_debouncer.sv
// Shared sample-pulse generator plus one saturating counter per channel;
// a channel reads as debounced once its counter has saturated.
module debouncer
  import button_parser_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] level_i,
  output logic [WIDTH-1:0] debounced_o
);

  localparam int SW = $clog2(SAMPLE_CNT_MAX);
  localparam int PW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PW-1:0] PULSE_FULL  = PW'(PULSE_CNT_MAX);

  logic [SW-1:0] sample_q, sample_d;
  logic          sample_pulse;
  logic [PW-1:0] cnt_q [WIDTH];
  logic [PW-1:0] cnt_d [WIDTH];

  always_comb begin
    sample_pulse = (sample_q == SAMPLE_LAST);
    if (sample_pulse) begin
      sample_d = '0;
    end else begin
      sample_d = sample_q + SW'(1);
    end
  end

  // A low level restarts the count immediately; a high level only advances on a sample.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]       = cnt_q[i];
      debounced_o[i] = (cnt_q[i] == PULSE_FULL);
      if (!level_i[i]) begin
        cnt_d[i] = '0;
      end else if (sample_pulse && (cnt_q[i] < PULSE_FULL)) begin
        cnt_d[i] = cnt_q[i] + PW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sample_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sample_q <= sample_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/button_parser.sv
// Raw push-button levels in, one clean single-cycle pulse per press out:
// two-flop synchronizer, debouncer, rising-edge detector.
module button_parser
  import button_parser_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] debounced;

  debouncer #(
    .WIDTH          (WIDTH),
    .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX),
    .PULSE_CNT_MAX  (PULSE_CNT_MAX)
  ) u_debouncer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .level_i     (sync2_q),
    .debounced_o (debounced)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      prev_q  <= debounced;
    end
  end

  // Decoded only from flops, so the pulse is glitch-free and one cycle wide.
  assign out = debounced & ~prev_q;

endmodule

// File: tb/tb_button_parser.sv
// Scoreboard bench: a reference model predicts out every cycle from the
// debounce rules; a monitor compares, and directed scenarios check pulse counts and latency.
module tb_button_parser;
  import button_parser_pkg::*;

  localparam int W = 4;
  localparam int S = SIM_SAMPLE_CNT_MAX;
  localparam int P = SIM_PULSE_CNT_MAX;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_s;
  logic [W-1:0] out_s;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int  pulse_cnt[W];
  time last_pulse_t[W];

  button_parser #(
    .WIDTH          (W),
    .SAMPLE_CNT_MAX (S),
    .PULSE_CNT_MAX  (P)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_s),
    .out   (out_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic hold(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Reference model: a channel is debounced once at least P sample instants have
  // passed with its synchronized level continuously high; sample instants fall
  // every S cycles counted from the last reset edge.
  initial begin : model
    int n, r, cnt;
    bit started, prev_valid;
    logic [W-1:0] in_prev, s2, e;
    bit deb_prev[W];
    int last_low[W];
    n = 0; r = 0; started = 1'b0; prev_valid = 1'b0; in_prev = '0;
    forever begin
      @(posedge clk);
      n++;
      if (rst_n === 1'b0) begin
        started = 1'b1;
        r = n;
        prev_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
          last_low[i] = n;
          deb_prev[i] = 1'b0;
        end
        exp_q.push_back('0);
      end else if (started) begin
        s2 = prev_valid ? in_prev : '0;
        for (int i = 0; i < W; i++) begin
          cnt = (n - r) / S - (last_low[i] - r + 1) / S;
          e[i] = (cnt >= P) && !deb_prev[i];
          deb_prev[i] = (cnt >= P);
          if (!s2[i]) last_low[i] = n;
        end
        exp_q.push_back(e);
        in_prev = in_s;
        prev_valid = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (out_s !== e) begin
          fails++;
          $display("FAIL out_vs_model: got %b, expected %b at %0t", out_s, e, $time);
        end
      end
      for (int i = 0; i < W; i++) begin
        if (out_s[i] === 1'b1) begin
          pulse_cnt[i]++;
          last_pulse_t[i] = $time;
        end
      end
    end
  end

  initial begin : stimulus
    int  b[W];
    time t_rise;
    for (int i = 0; i < W; i++) begin
      pulse_cnt[i] = 0;
      last_pulse_t[i] = 0;
    end
    rst_n = 1'b0;
    in_s  = '0;
    hold(3);
    rst_n = 1'b1;
    hold(50);
    check("idle_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);

    b = pulse_cnt;
    in_s = 4'b0001;
    t_rise = $time;
    hold(40);
    check("press_ch0_count", pulse_cnt[0] - b[0], 1);
    check("press_others", (pulse_cnt[1] - b[1]) + (pulse_cnt[2] - b[2]) + (pulse_cnt[3] - b[3]), 0);
    check_range("press_latency", int'((last_pulse_t[0] - t_rise) / 10), 10, 15);
    in_s = '0;
    hold(20);

    b = pulse_cnt;
    for (int k = 0; k < 10; k++) begin
      in_s = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      hold(3);
    end
    check("bounce_no_pulse", pulse_cnt[1] - b[1], 0);
    in_s = 4'b0010;
    t_rise = $time;
    hold(20);
    check("bounce_final_count", pulse_cnt[1] - b[1], 1);
    check_range("bounce_latency", int'((last_pulse_t[1] - t_rise) / 10), 10, 15);
    in_s = '0;
    hold(20);

    b = pulse_cnt;
    in_s = 4'b1010;
    hold(30);
    check("simul_ch1", pulse_cnt[1] - b[1], 1);
    check("simul_ch3", pulse_cnt[3] - b[3], 1);
    check("simul_ch0_ch2", (pulse_cnt[0] - b[0]) + (pulse_cnt[2] - b[2]), 0);
    check("simul_same_cycle", int'(last_pulse_t[1] == last_pulse_t[3]), 1);
    in_s = '0;
    hold(20);

    b = pulse_cnt;
    in_s = 4'b0100;
    hold(30);
    check("repress_first", pulse_cnt[2] - b[2], 1);
    in_s = '0;
    hold(10);
    in_s = 4'b0100;
    t_rise = $time;
    hold(30);
    check("repress_total", pulse_cnt[2] - b[2], 2);
    check_range("repress_latency", int'((last_pulse_t[2] - t_rise) / 10), 10, 15);
    in_s = '0;
    hold(20);

    b = pulse_cnt;
    in_s = 4'b0001;
    hold(8);
    check("rst_mid_before", pulse_cnt[0] - b[0], 0);
    rst_n = 1'b0;
    hold(2);
    rst_n = 1'b1;
    t_rise = $time;
    hold(30);
    check("rst_mid_after", pulse_cnt[0] - b[0], 1);
    check_range("rst_mid_latency", int'((last_pulse_t[0] - t_rise) / 10), 10, 15);
    in_s = '0;
    hold(20);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        hold($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      in_s = 4'($urandom);
      hold($urandom_range(1, 30));
    end
    in_s = '0;
    hold(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
